// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory among NUM_REQ requesters, one access per grant.
// Fixed priority by default; define DMEM_ARB_RR_EN for round-robin arbitration.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*2-1:0]            req_size,
    input  logic [NUM_REQ-1:0]              req_sign,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic                            mem_we,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic [1:0]                      mem_size,
    output logic                            mem_sign,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);
    localparam int IW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t                state;
    logic                  we, err, sign, gnt_any, sel_err, acc;
    logic [ADDR_WIDTH-1:0] addr, sel_addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [1:0]            size, sel_size;
    logic [IW-1:0]         owner, gnt_idx;
`ifdef DMEM_ARB_RR_EN
    logic [IW-1:0]         last_grant;
    // search descends so the port closest after last_grant is the final (winning) assignment
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'((int'(last_grant) + k) % NUM_REQ);
            end
    end
`else
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid[i]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(i);
            end
    end
`endif
    assign sel_addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_size  = req_size[gnt_idx*2 +: 2];
    assign sel_err   = (sel_size == 2'b01 && sel_addr[0]) || (sel_size[1] && sel_addr[1:0] != 2'b00);
    assign req_ready = (rst_n && state == IDLE && gnt_any) ? NUM_REQ'(1) << gnt_idx : '0;
    assign rsp_valid = (state == RESP) ? NUM_REQ'(1) << owner : '0;
    assign acc       = state == ACCESS;
    assign mem_we    = acc & we & ~err;
    assign mem_addr  = acc ? addr : '0;
    assign mem_wdata = acc ? wdata : '0;
    assign mem_size  = acc ? {size[1], size[0] & ~size[1]} : 2'b00;
    assign mem_sign  = acc & sign;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we        <= 1'b0;
            err       <= 1'b0;
            sign      <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            size      <= 2'b00;
            owner     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_grant <= IW'(NUM_REQ - 1);
`endif
        end else begin
            case (state)
                IDLE: if (gnt_any) begin
                    we    <= req_we[gnt_idx];
                    addr  <= sel_addr;
                    wdata <= req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                    size  <= sel_size;
                    sign  <= req_sign[gnt_idx];
                    err   <= sel_err;
                    owner <= gnt_idx;
`ifdef DMEM_ARB_RR_EN
                    last_grant <= gnt_idx;
`endif
                    state <= ACCESS;
                end
                ACCESS: begin
                    rsp_rdata <= (we || err) ? '0 : mem_rdata;
                    rsp_err   <= err;
                    state     <= RESP;
                end
                RESP: if (rsp_ready[owner]) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
